uart_echo_fifo: RTL

Parametrised UART echo/loopback harness for board bring-up of the core's serial link. It sits between the UART receiver and transmitter, requests bytes from the receiver, optionally transforms them, and buffers them in a DEPTH-entry FIFO. It then issues them to the transmitter, so RX and TX run concurrently instead of strictly alternating. An optional preloaded greeting byte is sent after reset, and traffic counters are exposed for debug LEDs and ILA probes.

---
 rtl/uart_echo_fifo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
// Loopback harness between a UART receiver and a UART transmitter. Bytes are
// requested from the receiver and optionally transformed on the way in. They
// are buffered in a DEPTH-entry circular FIFO and issued to the transmitter,
// so reception and transmission overlap. An optional greeting byte sits in
// the FIFO out of reset. Wrapping traffic counters are exposed for debug.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   mode            0 echo, 1 increment, 2 invert, 3 discard (sampled at push)
//   uart_in         received byte, qualified by uart_in_valid
//   uart_in_valid   receiver completion pulse
//   uart_in_ready   one-cycle receive request pulse
//   uart_out        byte to transmit, stable from request to completion
//   uart_out_ready  one-cycle transmit request pulse
//   uart_out_valid  transmitter completion pulse
//   fifo_level      current FIFO occupancy
//   rx_count        bytes accepted from the receiver
//   tx_count        bytes issued to the transmitter
//   drop_count      bytes discarded in mode 3
//
// state   | meaning
// RX_REQ  | ready to issue a receive request once the FIFO has room
// RX_WAIT | request issued, waiting for the receiver to complete
// TX_IDLE | issue the FIFO head to the transmitter as soon as one exists
// TX_WAIT | byte issued, waiting for the transmitter to complete
//
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module uart_echo_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int CNT_W     = 16,
  parameter int PRELOAD   = 1,
  parameter int INIT_DATA = 50
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic [DATA_W-1:0]      uart_in,
  input  logic                   uart_in_valid,
  output logic                   uart_in_ready,
  output logic [DATA_W-1:0]      uart_out,
  output logic                   uart_out_ready,
  input  logic                   uart_out_valid,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       rx_count,
  output logic [CNT_W-1:0]       tx_count,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {RX_REQ, RX_WAIT} rx_state_t;
  typedef enum logic {TX_IDLE, TX_WAIT} tx_state_t;

  rx_state_t         rx_state;
  tx_state_t         tx_state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] push_data;
  logic              rx_accept;
  logic              push;
  logic              pop;
  logic              full;

  always_comb begin
    push_data = uart_in;
    case (mode)
      2'd1:    push_data = uart_in + DATA_W'(1);
      2'd2:    push_data = ~uart_in;
      default: push_data = uart_in;
    endcase
  end

  assign rx_accept = (rx_state == RX_WAIT) && uart_in_valid;
  assign push      = rx_accept && (mode != 2'd3);
  assign pop       = (tx_state == TX_IDLE) && (fifo_level != '0);
  assign full      = (fifo_level == LW'(DEPTH));

  // Storage. A push can never hit a full FIFO because a receive request is
  // only issued with room available and nothing else pushes. A pop reads the
  // old head in the same cycle a push writes the tail, so the two never alias.
  // With a preloaded greeting in entry 0 the write pointer starts past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i == 0 && PRELOAD != 0) ? DATA_W'(INIT_DATA) : '0;
      wr_ptr     <= AW'(PRELOAD);
      rd_ptr     <= '0;
      fifo_level <= LW'(PRELOAD);
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        fifo_level <= fifo_level + LW'(1);
      else if (pop && !push)
        fifo_level <= fifo_level - LW'(1);
    end
  end

  // Receive side. Completion in the request cycle is accepted because the
  // state has already moved to RX_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state      <= RX_REQ;
      uart_in_ready <= 1'b0;
      rx_count      <= '0;
      drop_count    <= '0;
    end else begin
      case (rx_state)
        RX_REQ: begin
          if (!full) begin
            uart_in_ready <= 1'b1;
            rx_state      <= RX_WAIT;
          end
        end
        RX_WAIT: begin
          uart_in_ready <= 1'b0;
          if (uart_in_valid) begin
            rx_count <= rx_count + CNT_W'(1);
            if (mode == 2'd3)
              drop_count <= drop_count + CNT_W'(1);
            rx_state <= RX_REQ;
          end
        end
      endcase
    end
  end

  // Transmit side. uart_out only changes on issue, so it holds the byte for
  // the whole transfer and keeps the last byte while the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state       <= TX_IDLE;
      uart_out       <= '0;
      uart_out_ready <= 1'b0;
      tx_count       <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (pop) begin
            uart_out       <= mem[rd_ptr];
            uart_out_ready <= 1'b1;
            tx_count       <= tx_count + CNT_W'(1);
            tx_state       <= TX_WAIT;
          end
        end
        TX_WAIT: begin
          uart_out_ready <= 1'b0;
          if (uart_out_valid)
            tx_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule
